alu_pipe: RTL and testbench

//  Parametrised successor to the 4-bit opcode-driven ALU. Takes one operation

---
 rtl/alu_pipe.sv | 145 ++++++++++++++
 tb/tb_alu_pipe.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Opcode-driven ALU with valid/ready handshake, status flags and iterative multiply.
// Latency: single-cycle ops register on the accept edge; MUL completes WIDTH edges later.
// Backpressure: in_ready drops while busy or while a held result is not being taken.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags,
    output logic             err
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    localparam logic [3:0] OP_PASS = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_NOT = 4'h3,
                           OP_OR   = 4'h4, OP_AND = 4'h5, OP_XOR = 4'h6, OP_SHL = 4'h7,
                           OP_SHR  = 4'h8, OP_SAR = 4'h9, OP_SLT = 4'hA, OP_MUL = 4'hB;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state;
    logic [2*WIDTH-1:0] mul_a;    // multiplicand, widened so the full product is kept
    logic [WIDTH-1:0]   mul_b;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic [SW-1:0]      amt;
    logic [WIDTH:0]     add_w, sub_w, shl_w, shr_w, sar_w;
    logic [WIDTH-1:0]   res;
    logic               res_c, res_v, res_err;
    logic [2*WIDTH-1:0] acc_nxt;
    logic               accept;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign amt      = in_2[SW-1:0];

    assign add_w = {1'b0, in_1} + {1'b0, in_2};
    assign sub_w = {1'b0, in_1} - {1'b0, in_2};   // top bit is the borrow
    assign shl_w = {1'b0, in_1} << amt;           // top bit is the last bit shifted out
    assign shr_w = {in_1, 1'b0} >> amt;           // bottom bit is the last bit shifted out
    assign sar_w = $signed({in_1, 1'b0}) >>> amt;

    // One shift-add multiply step; also used for the result on the final step.
    assign acc_nxt = mul_b[0] ? (acc + mul_a) : acc;

    // Single-cycle result, carry and overflow for the presented opcode.
    always_comb begin
        res     = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        res_err = 1'b0;
        case (opcode)
            OP_PASS: res = in_1;
            OP_ADD: begin
                res   = add_w[WIDTH-1:0];
                res_c = add_w[WIDTH];
                res_v = (in_1[WIDTH-1] == in_2[WIDTH-1]) && (res[WIDTH-1] != in_1[WIDTH-1]);
            end
            OP_SUB: begin
                res   = sub_w[WIDTH-1:0];
                res_c = sub_w[WIDTH];
                res_v = (in_1[WIDTH-1] != in_2[WIDTH-1]) && (res[WIDTH-1] != in_1[WIDTH-1]);
            end
            OP_NOT: res = ~in_1;
            OP_OR:  res = in_1 | in_2;
            OP_AND: res = in_1 & in_2;
            OP_XOR: res = in_1 ^ in_2;
            OP_SHL: begin
                res   = shl_w[WIDTH-1:0];
                res_c = shl_w[WIDTH];
            end
            OP_SHR: begin
                res   = shr_w[WIDTH:1];
                res_c = shr_w[0];
            end
            OP_SAR: begin
                res   = sar_w[WIDTH:1];
                res_c = sar_w[0];
            end
            OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(in_1) < $signed(in_2))};
            OP_MUL: res = '0;   // handled by the iterative path
            default: res_err = 1'b1;
        endcase
    end

    // FSM, multiply datapath and registered result/handshake state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mul_a     <= '0;
            mul_b     <= '0;
            acc       <= '0;
            cnt       <= '0;
            out       <= '0;
            flags     <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && opcode == OP_MUL) begin
                        state     <= BUSY;
                        mul_a     <= {{WIDTH{1'b0}}, in_1};
                        mul_b     <= in_2;
                        acc       <= '0;
                        cnt       <= CW'(WIDTH);
                        out_valid <= 1'b0;
                    end else if (accept) begin
                        out       <= res;
                        flags     <= res_err ? 4'b0100
                                             : {res[WIDTH-1], (res == '0), res_c, res_v};
                        err       <= res_err;
                        out_valid <= 1'b1;
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                BUSY: begin
                    acc   <= acc_nxt;
                    mul_a <= mul_a << 1;
                    mul_b <= mul_b >> 1;
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= IDLE;
                        out       <= acc_nxt[WIDTH-1:0];
                        flags     <= {acc_nxt[WIDTH-1], (acc_nxt[WIDTH-1:0] == '0),
                                      (acc_nxt[2*WIDTH-1:WIDTH] != '0), 1'b0};
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe at WIDTH=8.
// Checks reset, arithmetic/shift/logic results, MUL latency, backpressure, err and mid-MUL reset.
// Inputs change 1ns after the rising edge; outputs are sampled 2ns after it.
module tb_alu_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] opcode = 4'h0;
    logic [7:0] in_1 = 8'h00;
    logic [7:0] in_2 = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out;
    logic [3:0] flags;
    logic       err;

    int checks = 0;
    int errors = 0;

    alu_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .in_1(in_1), .in_2(in_2), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .flags(flags), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance one clock; leaves time 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        opcode   = op;
        in_1     = a;
        in_2     = b;
    endtask

    // issue one single-cycle op with out_ready=1 and check the registered result
    task automatic single(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] eo, input logic [3:0] ef,
                          input logic ee);
        drive(op, a, b);
        step();
        in_valid = 1'b0;
        #1;
        chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_out"}, {24'd0, out}, {24'd0, eo});
        chk({tag, "_flg"}, {28'd0, flags}, {28'd0, ef});
        chk({tag, "_err"}, {31'd0, err}, {31'd0, ee});
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_vld", {31'd0, out_valid}, 32'd0);
        chk("rst_out", {24'd0, out}, 32'd0);
        chk("rst_flg", {28'd0, flags}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rdy", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ADD overflow: 0x7F+0x01 = 0x80, N=1 V=1
        single("add_ovf", 4'h1, 8'h7F, 8'h01, 8'h80, 4'b1001, 1'b0);

        // SUB then SAR back to back
        drive(4'h2, 8'h00, 8'h01);
        step();
        #1;
        chk("sub_out", {24'd0, out}, 32'hFF);
        chk("sub_flg", {28'd0, flags}, 32'b1010);
        drive(4'h9, 8'h80, 8'h03);
        step();
        in_valid = 1'b0;
        #1;
        chk("sar_vld", {31'd0, out_valid}, 32'd1);
        chk("sar_out", {24'd0, out}, 32'hF0);
        chk("sar_flg", {28'd0, flags}, 32'b1000);
        step();
        #1;
        chk("drain_vld", {31'd0, out_valid}, 32'd0);

        // extra directed single-cycle vectors
        single("add_cz", 4'h1, 8'hFF, 8'h01, 8'h00, 4'b0110, 1'b0);
        single("shl_c", 4'h7, 8'h81, 8'h01, 8'h02, 4'b0010, 1'b0);
        single("shl_0", 4'h7, 8'h81, 8'h08, 8'h81, 4'b1000, 1'b0);
        single("shr_c", 4'h8, 8'h03, 8'h01, 8'h01, 4'b0010, 1'b0);
        single("slt", 4'hA, 8'h80, 8'h01, 8'h01, 4'b0000, 1'b0);
        single("slt_n", 4'hA, 8'h01, 8'h80, 8'h00, 4'b0100, 1'b0);
        single("not", 4'h3, 8'h0F, 8'h00, 8'hF0, 4'b1000, 1'b0);
        single("sub_v", 4'h2, 8'h80, 8'h01, 8'h7F, 4'b0001, 1'b0);

        // MUL 0x13*0x0F = 0x11D
        drive(4'hB, 8'h13, 8'h0F);
        step();
        drive(4'h1, 8'h01, 8'h01);   // must not be taken while busy
        #1;
        chk("mul_rdy0", {31'd0, in_ready}, 32'd0);
        for (int i = 1; i < 8; i++) begin
            step();
            #1;
            chk($sformatf("mul_busy%0d", i), {30'd0, out_valid, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        step();
        #1;
        chk("mul_vld", {31'd0, out_valid}, 32'd1);
        chk("mul_out", {24'd0, out}, 32'h1D);
        chk("mul_flg", {28'd0, flags}, 32'b0010);
        step();
        #1;
        chk("mul_done", {31'd0, out_valid}, 32'd0);
        chk("mul_hold", {24'd0, out}, 32'h1D);

        // backpressure
        out_ready = 1'b0;
        drive(4'h6, 8'hAA, 8'hAA);
        step();
        drive(4'h4, 8'h0F, 8'hF0);
        #1;
        chk("bp_rdy", {31'd0, in_ready}, 32'd0);
        step();
        step();
        #1;
        chk("bp_vld", {31'd0, out_valid}, 32'd1);
        chk("bp_out", {24'd0, out}, 32'h00);
        chk("bp_flg", {28'd0, flags}, 32'b0100);
        chk("bp_rdy2", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_rdy3", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        #1;
        chk("bp_next_vld", {31'd0, out_valid}, 32'd1);
        chk("bp_next_out", {24'd0, out}, 32'hFF);
        chk("bp_next_flg", {28'd0, flags}, 32'b1000);

        // undefined opcode, then a valid op clears err
        single("undef", 4'hD, 8'h55, 8'h33, 8'h00, 4'b0100, 1'b1);
        single("pass", 4'h0, 8'h5A, 8'h00, 8'h5A, 4'b0000, 1'b0);
        step();

        // reset 3 cycles into a MUL
        drive(4'hB, 8'h13, 8'h0F);
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("mrst_vld", {31'd0, out_valid}, 32'd0);
        chk("mrst_out", {24'd0, out}, 32'h00);
        step();
        rst_n = 1'b1;
        #1;
        chk("mrst_rdy", {31'd0, in_ready}, 32'd1);
        begin
            int seen = 0;
            for (int i = 0; i < 10; i++) begin
                step();
                if (out_valid) seen++;
            end
            chk("mrst_stale", seen, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
